reception: RTL and testbench

Receive-path engine for the KSZ8851 Ethernet controller: polls the interrupt status, drains every queued frame through the RegIO register port, and streams frame words to a downstream consumer. Sits beside the initialization and transmission engines behind the RegIO arbitration muxes. It is the reader counterpart of the transmission engine and reports its phase to the bus-master selector through `receiveStatus`.

---
 rtl/ks_regs.sv | 50 +++++
 rtl/reg_access.sv | 75 +++++++
 rtl/reception.sv | 253 +++++++++++++++++++++++++
 tb/tb_reception.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ks_regs.sv
// Shared KSZ8851 register map, bit masks and RegIO command helpers used by the
// reception, transmission and initialization engines.
package ks_regs;

   localparam logic [7:0] REG_ISR     = 8'h92;
   localparam logic [7:0] REG_RXFCTR  = 8'h9C;
   localparam logic [7:0] REG_RXFHSR  = 8'h7C;
   localparam logic [7:0] REG_RXFHBCR = 8'h7E;
   localparam logic [7:0] REG_RXFDPR  = 8'h86;
   localparam logic [7:0] REG_RXQCR   = 8'h82;

   localparam logic [15:0] ISR_RXIS      = 16'h2000;
   localparam logic [15:0] RXFHSR_RXFV   = 16'h8000;
   localparam logic [15:0] RXFHSR_ERR    = 16'h003F;
   localparam logic [15:0] RXQCR_SDA     = 16'h0008;
   localparam logic [15:0] RXQCR_RRXEF   = 16'h0001;
   localparam logic [15:0] RXFDPR_RXFPAI = 16'h5000;

   typedef enum logic [1:0] {
      RS_SETUP    = 2'b00,
      RS_XFER     = 2'b01,
      RS_INACTIVE = 2'b10,
      RS_RELEASE  = 2'b11
   } rx_status_e;

   typedef struct packed {
      logic [7:0]  offset;
      logic        wr;
      logic [15:0] wdata;
      logic        dq;
   } regio_cmd_t;

   function automatic regio_cmd_t rd_cmd(input logic [7:0] off);
      rd_cmd = '{offset: off, wr: 1'b0, wdata: 16'h0000, dq: 1'b0};
   endfunction

   function automatic regio_cmd_t wr_cmd(input logic [7:0] off, input logic [15:0] data);
      wr_cmd = '{offset: off, wr: 1'b1, wdata: data, dq: 1'b0};
   endfunction

   function automatic regio_cmd_t qrd_cmd();
      qrd_cmd = '{offset: 8'h00, wr: 1'b0, wdata: 16'h0000, dq: 1'b1};
   endfunction

   // 16-bit queue reads needed for a frame: byte count rounded up to dwords.
   function automatic logic [10:0] rx_words(input logic [11:0] len);
      return 11'(((13'(len) + 13'd3) >> 2) << 1);
   endfunction

endpackage

// File: rtl/reg_access.sv
// Single RegIO access: issue a one-cycle command, wait for RegIO to go busy and
// return idle, then signal done with the read result valid in that cycle.
module reg_access
   import ks_regs::*;
(
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        start_i,
   input  regio_cmd_t  cmd_i,
   input  logic [3:0]  state_i,
   input  logic [15:0] read_data_i,
   output logic [7:0]  offset_o,
   output logic        wr_o,
   output logic [15:0] write_data_o,
   output logic        data_queue_o,
   output logic        new_command_o,
   output logic        done_o,
   output logic [15:0] rdata_o
);

   localparam logic [1:0] PH_IDLE      = 2'd0;
   localparam logic [1:0] PH_WAIT_BUSY = 2'd1;
   localparam logic [1:0] PH_WAIT_IDLE = 2'd2;

   logic [1:0] phase_q, phase_d;
   regio_cmd_t cmd_q, cmd_d;
   logic       new_cmd_q, new_cmd_d;

   always_comb begin
      phase_d   = phase_q;
      cmd_d     = cmd_q;
      new_cmd_d = 1'b0;
      done_o    = 1'b0;
      case (phase_q)
         PH_IDLE: begin
            if (start_i && (state_i == 4'd0)) begin
               cmd_d     = cmd_i;
               new_cmd_d = 1'b1;
               phase_d   = PH_WAIT_BUSY;
            end
         end
         PH_WAIT_BUSY: begin
            if (state_i != 4'd0) phase_d = PH_WAIT_IDLE;
         end
         PH_WAIT_IDLE: begin
            if (state_i == 4'd0) begin
               done_o  = 1'b1;
               phase_d = PH_IDLE;
            end
         end
         default: phase_d = PH_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         phase_q   <= PH_IDLE;
         cmd_q     <= '0;
         new_cmd_q <= 1'b0;
      end else begin
         phase_q   <= phase_d;
         cmd_q     <= cmd_d;
         new_cmd_q <= new_cmd_d;
      end
   end

   // Command fields are held in cmd_q, so they stay stable through the access.
   assign offset_o      = cmd_q.offset;
   assign wr_o          = cmd_q.wr;
   assign write_data_o  = cmd_q.wdata;
   assign data_queue_o  = cmd_q.dq;
   assign new_command_o = new_cmd_q;
   assign rdata_o       = read_data_i;

endmodule

// File: rtl/reception.sv
// KSZ8851 receive engine: polls ISR, drains queued frames over RegIO and
// streams frame words downstream, releasing bad frames through RRXEF.
module reception
   import ks_regs::*;
#(
   parameter int unsigned POLL_GAP = 64,
   parameter int unsigned MAX_LEN  = 2000
) (
   input  logic        clk40m,
   input  logic        RSTN,
   input  logic        recevEn,
   input  logic [3:0]  state,
   input  logic [15:0] readData,
   output logic [7:0]  offset,
   output logic        length,
   output logic        WR,
   output logic [15:0] writeData,
   output logic        NewCommand,
   output logic        DataQueue,
   output logic [1:0]  receiveStatus,
   output logic [15:0] rxData,
   output logic        rxValid,
   output logic        rxSof,
   output logic        rxEof,
   output logic [11:0] rxLen
);

   localparam int unsigned PW = $clog2(POLL_GAP + 1);

   localparam logic [3:0] S_IDLE     = 4'd0;
   localparam logic [3:0] S_RD_ISR   = 4'd1;
   localparam logic [3:0] S_POLL     = 4'd2;
   localparam logic [3:0] S_ACK_ISR  = 4'd3;
   localparam logic [3:0] S_RD_FCNT  = 4'd4;
   localparam logic [3:0] S_RD_FHS   = 4'd5;
   localparam logic [3:0] S_RD_FHBC  = 4'd6;
   localparam logic [3:0] S_SET_FDP  = 4'd7;
   localparam logic [3:0] S_SET_SDA  = 4'd8;
   localparam logic [3:0] S_DUMMY    = 4'd9;
   localparam logic [3:0] S_RD_STAT  = 4'd10;
   localparam logic [3:0] S_RD_LEN   = 4'd11;
   localparam logic [3:0] S_RD_DATA  = 4'd12;
   localparam logic [3:0] S_CLR_SDA  = 4'd13;
   localparam logic [3:0] S_DROP     = 4'd14;
   localparam logic [3:0] S_DROP_CHK = 4'd15;

   logic [3:0]    st_q, st_d;
   logic [PW-1:0] poll_q, poll_d;
   logic [7:0]    fcnt_q, fcnt_d;
   logic          bad_q, bad_d;
   logic [11:0]   rx_len_q, rx_len_d;
   logic [10:0]   nwords_q, nwords_d;
   logic [10:0]   widx_q, widx_d;
   logic [15:0]   rx_data_q, rx_data_d;
   logic          rx_valid_q, rx_valid_d;
   logic          rx_sof_q, rx_sof_d;
   logic          rx_eof_q, rx_eof_d;

   logic          start;
   regio_cmd_t    cmd;
   logic          done;
   logic [15:0]   rdata;
   logic [11:0]   rd_len;
   logic          frame_end;

   assign rd_len = rdata[11:0];

   reg_access u_reg_access (
      .clk_i         (clk40m),
      .rst_ni        (RSTN),
      .start_i       (start),
      .cmd_i         (cmd),
      .state_i       (state),
      .read_data_i   (readData),
      .offset_o      (offset),
      .wr_o          (WR),
      .write_data_o  (writeData),
      .data_queue_o  (DataQueue),
      .new_command_o (NewCommand),
      .done_o        (done),
      .rdata_o       (rdata)
   );

   always_comb begin
      st_d       = st_q;
      poll_d     = poll_q;
      fcnt_d     = fcnt_q;
      bad_d      = bad_q;
      rx_len_d   = rx_len_q;
      nwords_d   = nwords_q;
      widx_d     = widx_q;
      rx_data_d  = rx_data_q;
      rx_valid_d = 1'b0;
      rx_sof_d   = 1'b0;
      rx_eof_d   = 1'b0;
      start      = 1'b0;
      cmd        = '0;
      frame_end  = 1'b0;
      case (st_q)
         S_IDLE: begin
            if (recevEn) st_d = S_RD_ISR;
         end
         S_RD_ISR: begin
            start = 1'b1;
            cmd   = rd_cmd(REG_ISR);
            if (done) begin
               if ((rdata & ISR_RXIS) != 16'h0000) begin
                  st_d = S_ACK_ISR;
               end else begin
                  poll_d = PW'(POLL_GAP - 1);
                  st_d   = S_POLL;
               end
            end
         end
         S_POLL: begin
            if (poll_q == '0) st_d = S_RD_ISR;
            else poll_d = poll_q - PW'(1);
         end
         S_ACK_ISR: begin
            start = 1'b1;
            cmd   = wr_cmd(REG_ISR, ISR_RXIS);
            if (done) st_d = S_RD_FCNT;
         end
         S_RD_FCNT: begin
            start = 1'b1;
            cmd   = rd_cmd(REG_RXFCTR);
            if (done) begin
               fcnt_d = rdata[15:8];
               st_d   = (rdata[15:8] == 8'd0) ? S_IDLE : S_RD_FHS;
            end
         end
         S_RD_FHS: begin
            start = 1'b1;
            cmd   = rd_cmd(REG_RXFHSR);
            if (done) begin
               bad_d = ((rdata & RXFHSR_RXFV) == 16'h0000) || ((rdata & RXFHSR_ERR) != 16'h0000);
               st_d  = S_RD_FHBC;
            end
         end
         S_RD_FHBC: begin
            start = 1'b1;
            cmd   = rd_cmd(REG_RXFHBCR);
            if (done) begin
               rx_len_d = rd_len;
               nwords_d = rx_words(rd_len);
               if (bad_q || (rd_len < 12'd4) || (32'(rd_len) > MAX_LEN)) st_d = S_DROP;
               else st_d = S_SET_FDP;
            end
         end
         S_SET_FDP: begin
            start = 1'b1;
            cmd   = wr_cmd(REG_RXFDPR, RXFDPR_RXFPAI);
            if (done) st_d = S_SET_SDA;
         end
         S_SET_SDA: begin
            start = 1'b1;
            cmd   = wr_cmd(REG_RXQCR, RXQCR_SDA);
            if (done) st_d = S_DUMMY;
         end
         // Dummy, status and length words precede the frame data in the queue.
         S_DUMMY, S_RD_STAT, S_RD_LEN: begin
            start = 1'b1;
            cmd   = qrd_cmd();
            if (done) begin
               widx_d = 11'd0;
               st_d   = st_q + 4'd1;
            end
         end
         S_RD_DATA: begin
            start = 1'b1;
            cmd   = qrd_cmd();
            if (done) begin
               rx_data_d  = rdata;
               rx_valid_d = 1'b1;
               rx_sof_d   = (widx_q == 11'd0);
               rx_eof_d   = (widx_q == nwords_q - 11'd1);
               widx_d     = widx_q + 11'd1;
               if (widx_q == nwords_q - 11'd1) st_d = S_CLR_SDA;
            end
         end
         S_CLR_SDA: begin
            start = 1'b1;
            cmd   = wr_cmd(REG_RXQCR, 16'h0000);
            if (done) frame_end = 1'b1;
         end
         S_DROP: begin
            start = 1'b1;
            cmd   = wr_cmd(REG_RXQCR, RXQCR_RRXEF);
            if (done) st_d = S_DROP_CHK;
         end
         S_DROP_CHK: begin
            start = 1'b1;
            cmd   = rd_cmd(REG_RXQCR);
            if (done && ((rdata & RXQCR_RRXEF) == 16'h0000)) frame_end = 1'b1;
         end
         default: st_d = S_IDLE;
      endcase

      if (frame_end) begin
         fcnt_d = (fcnt_q == 8'd0) ? 8'd0 : fcnt_q - 8'd1;
         if (!recevEn) st_d = S_IDLE;
         else if (fcnt_d != 8'd0) st_d = S_RD_FHS;
         else st_d = S_RD_ISR;
      end
   end

   always_ff @(posedge clk40m or negedge RSTN) begin
      if (!RSTN) begin
         st_q       <= S_IDLE;
         poll_q     <= '0;
         fcnt_q     <= 8'd0;
         bad_q      <= 1'b0;
         rx_len_q   <= 12'd0;
         nwords_q   <= 11'd0;
         widx_q     <= 11'd0;
         rx_data_q  <= 16'h0000;
         rx_valid_q <= 1'b0;
         rx_sof_q   <= 1'b0;
         rx_eof_q   <= 1'b0;
      end else begin
         st_q       <= st_d;
         poll_q     <= poll_d;
         fcnt_q     <= fcnt_d;
         bad_q      <= bad_d;
         rx_len_q   <= rx_len_d;
         nwords_q   <= nwords_d;
         widx_q     <= widx_d;
         rx_data_q  <= rx_data_d;
         rx_valid_q <= rx_valid_d;
         rx_sof_q   <= rx_sof_d;
         rx_eof_q   <= rx_eof_d;
      end
   end

   always_comb begin
      receiveStatus = RS_SETUP;
      case (st_q)
         S_IDLE:                       receiveStatus = RS_INACTIVE;
         S_SET_SDA, S_DUMMY, S_RD_STAT,
         S_RD_LEN, S_RD_DATA, S_CLR_SDA: receiveStatus = RS_XFER;
         S_DROP, S_DROP_CHK:           receiveStatus = RS_RELEASE;
         default:                      receiveStatus = RS_SETUP;
      endcase
   end

   assign length  = 1'b1;
   assign rxData  = rx_data_q;
   assign rxValid = rx_valid_q;
   assign rxSof   = rx_sof_q;
   assign rxEof   = rx_eof_q;
   assign rxLen   = rx_len_q;

endmodule

// File: tb/tb_reception.sv
// Self-checking bench for reception: behavioural KSZ8851 RegIO model with a
// frame queue, and a scoreboard of expected frame words.
module tb_reception;
   import ks_regs::*;

   localparam int unsigned PG = 16;
   localparam int unsigned ML = 2000;

   logic        clk40m = 1'b0;
   logic        RSTN = 1'b0;
   logic        recevEn = 1'b0;
   logic [3:0]  state = 4'd0;
   logic [15:0] readData = 16'h0000;
   logic [7:0]  offset;
   logic        length, WR, NewCommand, DataQueue, rxValid, rxSof, rxEof;
   logic [15:0] writeData, rxData;
   logic [1:0]  receiveStatus;
   logic [11:0] rxLen;

   reception #(.POLL_GAP(PG), .MAX_LEN(ML)) dut (
      .clk40m        (clk40m),
      .RSTN          (RSTN),
      .recevEn       (recevEn),
      .state         (state),
      .readData      (readData),
      .offset        (offset),
      .length        (length),
      .WR            (WR),
      .writeData     (writeData),
      .NewCommand    (NewCommand),
      .DataQueue     (DataQueue),
      .receiveStatus (receiveStatus),
      .rxData        (rxData),
      .rxValid       (rxValid),
      .rxSof         (rxSof),
      .rxEof         (rxEof),
      .rxLen         (rxLen)
   );

   always #12 clk40m = ~clk40m;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   always @(posedge clk40m) cyc <= cyc + 1;

   // Chip model state
   logic [15:0] fr_fhs[16];
   logic [11:0] fr_len[16];
   int          fr_nw[16];
   int          fr_base[16];
   logic [15:0] pool[4096];
   int n_fr, cur_fr, pool_top, qidx, busy_cnt, isr_reads, last_isr, min_gap, max_gap;
   int rx_total, sof_cnt, eof_cnt, q_reads, exp_qreads, exp_good, cmd_cnt;
   bit acked, rrxef_pend;
   logic [15:0] exp_data[$];
   logic        exp_sof[$];
   logic        exp_eof[$];
   logic [15:0] exp82[$];
   logic [15:0] w82[$];
   logic [7:0]  c_off;
   logic        c_wr, c_dq;
   logic [15:0] c_wd, resp;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic serve();
      int k;
      resp = $urandom;
      if (c_dq) begin
         q_reads++;
         k = qidx - 3;
         if (qidx >= 3) resp = (cur_fr < n_fr && k < fr_nw[cur_fr]) ? pool[fr_base[cur_fr] + k] : 16'h0;
         qidx++;
      end else if (c_wr) begin
         if (c_off == REG_ISR && c_wd[13]) acked = 1'b1;
         if (c_off == REG_RXFDPR) begin
            check("fdp_value", c_wd, 16'h5000);
            if (cur_fr < n_fr) check("rxlen_good", rxLen, fr_len[cur_fr]);
         end
         if (c_off == REG_RXQCR) begin
            w82.push_back(c_wd);
            if (c_wd == 16'h0001) begin
               check("drop_status", receiveStatus, 2'b11);
               if (cur_fr < n_fr) check("rxlen_drop", rxLen, fr_len[cur_fr]);
               cur_fr++;
               rrxef_pend = 1'b1;
            end else begin
               check("sda_status", receiveStatus, 2'b01);
               if (c_wd == 16'h0008) qidx = 0;
               else cur_fr++;
            end
         end
      end else begin
         case (c_off)
            REG_ISR: begin
               isr_reads++;
               if (last_isr >= 0) begin
                  if (cyc - last_isr < min_gap) min_gap = cyc - last_isr;
                  if (cyc - last_isr > max_gap) max_gap = cyc - last_isr;
               end
               last_isr = cyc;
               resp = (resp & 16'hDFFF) | ((cur_fr < n_fr && !acked) ? 16'h2000 : 16'h0);
            end
            REG_RXFCTR:  resp = {8'(n_fr - cur_fr), resp[7:0]};
            REG_RXFHSR:  resp = (cur_fr < n_fr) ? fr_fhs[cur_fr] : 16'h0;
            REG_RXFHBCR: resp = {resp[15:12], (cur_fr < n_fr) ? fr_len[cur_fr] : 12'h0};
            REG_RXQCR: begin
               resp = rrxef_pend ? 16'h0001 : 16'h0000;
               rrxef_pend = 1'b0;
            end
            default: resp = 16'h0;
         endcase
      end
   endtask

   // RegIO responder: goes busy for 1-3 cycles per command.
   initial begin
      forever begin
         @(negedge clk40m);
         if (!RSTN) begin
            state = 4'd0;
            busy_cnt = 0;
         end else begin
            if (NewCommand) check("issue_when_idle", state, 4'd0);
            if (busy_cnt > 0) begin
               busy_cnt--;
               if (busy_cnt == 0) begin
                  check("cmd_stable", {offset, WR, writeData, DataQueue}, {c_off, c_wr, c_wd, c_dq});
                  state = 4'd0;
                  readData = resp;
               end
            end else if (NewCommand) begin
               cmd_cnt++;
               c_off = offset; c_wr = WR; c_wd = writeData; c_dq = DataQueue;
               serve();
               state = 4'd5;
               busy_cnt = $urandom_range(1, 3);
            end
         end
      end
   end

   // Downstream scoreboard
   initial begin
      logic [15:0] d;
      logic s, e;
      forever begin
         @(negedge clk40m);
         if (RSTN && rxValid) begin
            rx_total++;
            if (rxSof) sof_cnt++;
            if (rxEof) eof_cnt++;
            check("xfer_status", receiveStatus, 2'b01);
            check("rx_expected", exp_data.size() > 0, 1);
            if (exp_data.size() > 0) begin
               d = exp_data.pop_front();
               s = exp_sof.pop_front();
               e = exp_eof.pop_front();
               check("rx_word", {rxSof, rxEof, rxData}, {s, e, d});
            end
         end
      end
   end

   task automatic check_reset_vals(input string tag);
      check({tag, "_ctl"}, {receiveStatus, NewCommand, rxValid, rxSof, rxEof, WR, DataQueue, length},
            {2'b10, 6'b000000, 1'b1});
      check({tag, "_offset"}, offset, 8'h00);
      check({tag, "_wdata"}, writeData, 16'h0000);
      check({tag, "_rxdata"}, rxData, 16'h0000);
      check({tag, "_rxlen"}, rxLen, 12'h000);
   endtask

   task automatic do_reset();
      RSTN = 1'b0;
      recevEn = 1'b0;
      repeat (2) @(negedge clk40m);
      n_fr = 0; cur_fr = 0; pool_top = 0; qidx = 0; isr_reads = 0; last_isr = -1;
      min_gap = 1000000; max_gap = 0; rx_total = 0; sof_cnt = 0; eof_cnt = 0;
      q_reads = 0; exp_qreads = 0; exp_good = 0; cmd_cnt = 0; acked = 1'b0; rrxef_pend = 1'b0;
      exp_data.delete(); exp_sof.delete(); exp_eof.delete(); exp82.delete(); w82.delete();
      @(negedge clk40m);
      RSTN = 1'b1;
      @(negedge clk40m);
   endtask

   task automatic add_frame(input logic [15:0] fhs, input logic [11:0] len);
      bit good;
      int nw;
      logic [15:0] w;
      good = fhs[15] && (fhs[5:0] == 6'd0) && (len >= 12'd4) && (int'(len) <= ML);
      nw = ((int'(len) + 3) / 4) * 2;
      fr_fhs[n_fr] = fhs;
      fr_len[n_fr] = len;
      fr_base[n_fr] = pool_top;
      fr_nw[n_fr] = good ? nw : 0;
      if (good) begin
         for (int i = 0; i < nw; i++) begin
            w = 16'($urandom);
            pool[pool_top + i] = w;
            exp_data.push_back(w);
            exp_sof.push_back(i == 0);
            exp_eof.push_back(i == nw - 1);
         end
         pool_top += nw;
         exp82.push_back(16'h0008);
         exp82.push_back(16'h0000);
         exp_good++;
         exp_qreads += nw + 3;
      end else begin
         exp82.push_back(16'h0001);
      end
      n_fr++;
   endtask

   task automatic run_session(input string tag, input int budget);
      int g, r;
      recevEn = 1'b1;
      g = 0;
      while (cur_fr < n_fr && g < budget) begin @(negedge clk40m); g++; end
      r = isr_reads;
      while (isr_reads == r && g < budget) begin @(negedge clk40m); g++; end
      recevEn = 1'b0;
      check({tag, "_in_time"}, g < budget, 1);
      check({tag, "_words_left"}, exp_data.size(), 0);
      check({tag, "_sof"}, sof_cnt, exp_good);
      check({tag, "_eof"}, eof_cnt, exp_good);
      check({tag, "_qreads"}, q_reads, exp_qreads);
      check({tag, "_n82"}, w82.size(), exp82.size());
      for (int i = 0; i < exp82.size() && i < w82.size(); i++) check({tag, "_w82"}, w82[i], exp82[i]);
   endtask

   initial begin
      int g, bad_st, c;
      RSTN = 1'b0;
      #30;
      check_reset_vals("reset");
      do_reset();

      // No RXIS: periodic polling only
      recevEn = 1'b1;
      repeat (3) @(negedge clk40m);
      bad_st = 0;
      for (int i = 0; i < 6 * (PG + 8); i++) begin
         @(negedge clk40m);
         if (receiveStatus != 2'b00) bad_st++;
      end
      check("poll_count", isr_reads >= 4, 1);
      check("poll_min_gap", min_gap >= PG, 1);
      check("poll_max_gap", max_gap <= PG + 10, 1);
      check("poll_status", bad_st, 0);
      check("poll_no_rx", rx_total, 0);
      check("poll_only_isr", cmd_cnt, isr_reads);

      do_reset();
      add_frame(16'h8000, 12'd64);
      run_session("len64", 3000);
      check("len64_words", rx_total, 32);
      check("len64_rxlen", rxLen, 12'd64);

      do_reset();
      add_frame(16'h8000, 12'd61);
      add_frame(16'h8000, 12'd5);
      run_session("len61_5", 3000);
      check("len61_5_words", rx_total, 36);

      do_reset();
      add_frame(16'h8001, 12'd64);
      add_frame(16'h0000, 12'd64);
      add_frame(16'h8000, 12'd2100);
      add_frame(16'h8000, 12'd2);
      add_frame(16'h8000, 12'd2001);
      run_session("drops", 3000);
      check("drops_no_rx", rx_total, 0);

      do_reset();
      add_frame(16'h8000, 12'd64);
      add_frame(16'h8000, 12'd128);
      add_frame(16'h8000, 12'd60);
      run_session("three", 6000);
      check("three_words", rx_total, 126);

      do_reset();
      add_frame(16'h8000, 12'd4);
      add_frame(16'hFFC0, 12'd2000);
      run_session("bounds", 12000);
      check("bounds_words", rx_total, 1002);

      do_reset();
      for (int i = 0; i < 6; i++) begin
         if ($urandom_range(0, 3) == 0) add_frame(16'($urandom), 12'($urandom_range(1, 300)));
         else if ($urandom_range(0, 5) == 0) add_frame(16'h8000, 12'($urandom_range(2001, 2100)));
         else add_frame(16'h8000 | (16'($urandom) & 16'h7FC0), 12'($urandom_range(1, 300)));
      end
      run_session("random", 12000);

      // Reset in the middle of a frame
      do_reset();
      add_frame(16'h8000, 12'd64);
      recevEn = 1'b1;
      g = 0;
      while (rx_total < 10 && g < 2000) begin @(negedge clk40m); g++; end
      check("rstmid_reached", g < 2000, 1);
      RSTN = 1'b0;
      #1;
      check_reset_vals("rst_mid");

      // Enable dropped mid-frame: finish frame, then idle
      do_reset();
      add_frame(16'h8000, 12'd64);
      add_frame(16'h8000, 12'd64);
      recevEn = 1'b1;
      g = 0;
      while (rx_total < 5 && g < 2000) begin @(negedge clk40m); g++; end
      recevEn = 1'b0;
      while (receiveStatus != 2'b10 && g < 4000) begin @(negedge clk40m); g++; end
      check("en_drop_idle", g < 4000, 1);
      check("en_drop_words", rx_total, 32);
      check("en_drop_eof", eof_cnt, 1);
      check("en_drop_frames", cur_fr, 1);
      check("en_drop_n82", w82.size(), 2);
      c = cmd_cnt;
      repeat (60) @(negedge clk40m);
      check("en_drop_quiet", cmd_cnt, c);
      check("en_drop_status", receiveStatus, 2'b10);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
